// File: rtl/mbm_seq_mult_ctrl_if.sv
// Handshake and operand/product bus for the sequential Mitchell multiplier.
interface mbm_seq_mult_ctrl_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;

  // Producer/consumer side: supplies operands and accepts the product.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mbm_seq_mult_ctrl.sv
// Sequential Mitchell (MBM) approximate multiplier controller.
// Fixed latency: N cycles of leading-one scan, one add cycle, one normalise cycle.
module mbm_seq_mult_ctrl #(
  parameter int N = 8,
  parameter int L = 3
) (
  input logic                clk,
  input logic                rst_n,
  mbm_seq_mult_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOD  = 3'd1,
    ADD  = 3'd2,
    NORM = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   a_r, b_r;
  logic [L-1:0]   cnt;
  logic [L-1:0]   k_a, k_b;
  logic           found_a, found_b;
  logic           zero_flag;
  logic           carry;
  logic [N-2:0]   frac;
  logic           out_valid_r;
  logic [2*N-1:0] product_r;

  logic           found_a_n, found_b_n;
  logic [N-1:0]   sh_a, sh_b;
  logic [N-2:0]   f_a, f_b;
  logic [N-1:0]   sum;
  logic [L:0]     e;
  logic [3*N-2:0] wide;
  logic [3*N-2:0] prod_w;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_n      = state;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b1;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_n = LOD;
      end
      LOD:  if (cnt == '0) state_n = ADD;
      ADD:  state_n = NORM;
      NORM: state_n = DONE;
      DONE: if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Fraction extraction, fraction add and normalisation datapath.
  always_comb begin
    found_a_n = found_a | a_r[cnt];
    found_b_n = found_b | b_r[cnt];
    sh_a      = a_r << (L'(N-1) - k_a);
    sh_b      = b_r << (L'(N-1) - k_b);
    f_a       = sh_a[N-2:0];
    f_b       = sh_b[N-2:0];
    sum       = {1'b0, f_a} + {1'b0, f_b};
    e         = {1'b0, k_a} + {1'b0, k_b} + {{L{1'b0}}, carry};
    wide      = {{(2*N-1){1'b0}}, 1'b1, frac} << e;
    prod_w    = wide >> (N-1);
  end

  // Operand capture, leading-one scan and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      cnt         <= '0;
      k_a         <= '0;
      k_b         <= '0;
      found_a     <= 1'b0;
      found_b     <= 1'b0;
      zero_flag   <= 1'b0;
      carry       <= 1'b0;
      frac        <= '0;
      out_valid_r <= 1'b0;
      product_r   <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          a_r       <= bus.a;
          b_r       <= bus.b;
          cnt       <= L'(N-1);
          k_a       <= '0;
          k_b       <= '0;
          found_a   <= 1'b0;
          found_b   <= 1'b0;
          zero_flag <= 1'b0;
        end
        LOD: begin
          // Scan runs high to low, so the first hit is the leading one.
          if (!found_a && a_r[cnt]) k_a <= cnt;
          if (!found_b && b_r[cnt]) k_b <= cnt;
          found_a <= found_a_n;
          found_b <= found_b_n;
          cnt     <= cnt - 1'b1;
          if (cnt == '0) zero_flag <= ~found_a_n | ~found_b_n;
        end
        ADD: {carry, frac} <= sum;
        NORM: begin
          product_r   <= zero_flag ? '0 : prod_w[2*N-1:0];
          out_valid_r <= 1'b1;
        end
        DONE: if (bus.out_ready) out_valid_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.product   = product_r;

endmodule

// File: tb/tb_mbm_seq_mult_ctrl.sv
// Directed bench for mbm_seq_mult_ctrl with hand-computed Mitchell products.
module tb_mbm_seq_mult_ctrl;

  localparam int N = 8;
  localparam int L = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mbm_seq_mult_ctrl_if #(.N(N)) bus ();

  mbm_seq_mult_ctrl #(.N(N), .L(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One transaction: accept, measure latency, optionally hold in DONE, then hand off.
  task automatic run(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                     input int expv, input int hold, input bit glitch);
    int lat;
    bit seen;
    logic [2*N-1:0] p0;
    @(negedge clk);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    if (glitch) begin
      bus.a        = 8'd12;
      bus.b        = 8'd10;
      bus.in_valid = 1'b1;
    end
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
      else lat++;
      if (glitch && i == 1) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    check({tag, "_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_lat"}, lat, N + 2);
    check({tag, "_prod"}, {16'd0, bus.product}, expv);
    p0 = bus.product;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_v"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, "_hold_p"}, {16'd0, bus.product}, {16'd0, p0});
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_ov_clr"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_in_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_keep_p"}, {16'd0, bus.product}, expv);
  endtask

  initial begin
    bit stray;
    checks        = 0;
    failures      = 0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #2;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_product", {16'd0, bus.product}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run("m12x10", 8'd12, 8'd10, 112, 0, 1'b0);
    run("m12x12", 8'd12, 8'd12, 128, 0, 1'b0);
    run("m255x255", 8'd255, 8'd255, 65024, 0, 1'b0);
    run("m1x1", 8'd1, 8'd1, 1, 0, 1'b0);
    run("m3x5", 8'd3, 8'd5, 14, 0, 1'b0);
    run("m128x2", 8'd128, 8'd2, 256, 0, 1'b0);
    run("m0x200", 8'd0, 8'd200, 0, 0, 1'b1);
    run("hold", 8'd12, 8'd10, 112, 5, 1'b0);

    // Reset in the 4th LOD cycle discards the transaction.
    @(negedge clk);
    bus.a        = 8'd255;
    bus.b        = 8'd255;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("lod_busy", {31'd0, bus.busy}, 32'd1);
    check("lod_in_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_product", {16'd0, bus.product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) stray = 1'b1;
    end
    check("no_stray_valid", {31'd0, stray}, 32'd0);
    run("post_rst", 8'd12, 8'd10, 112, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mbm_seq_mult_ctrl.md
MBM_SEQ_MULT_CTRL -- requirements
Module: mbm_seq_mult_ctrl

Interface
REQ-001 Parameter N, default 8: operand width in bits; the fractional datapath is N-1 bits.
REQ-002 Parameter L, default 3: log2(N); leading-one position width in bits.
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand pair on a/b is valid.
REQ-006 in_ready  output  1  block can accept an operand pair; high only in IDLE.
REQ-007 a  input  N  unsigned multiplicand.
REQ-008 b  input  N  unsigned multiplier.
REQ-009 out_valid  output  1  product is valid; held until accepted.
REQ-010 out_ready  input  1  consumer accepts the product.
REQ-011 product  output  2N  unsigned Mitchell (MBM) approximate product of a and b.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, LOD, ADD, NORM and DONE.
REQ-014 IDLE: an accept occurs when in_valid=1 at a rising edge; the block SHALL latch a and b into internal registers and go to LOD.
REQ-015 in_valid SHALL be ignored in every state other than IDLE; a and b SHALL NOT be resampled after acceptance.
REQ-016 LOD: a counter SHALL scan bit indices N-1 down to 0, one index per cycle, for both operands in parallel, and SHALL spend exactly N cycles in LOD.
REQ-017 During LOD, the block SHALL capture k_a (and likewise k_b) as the index of the highest set bit; once a one has been captured, lower indices SHALL NOT overwrite it.
REQ-018 zero_flag SHALL be set when either operand has no set bit; LOD duration SHALL still be N cycles (fixed latency).
REQ-019 Fractional part: f_a SHALL be the bits of a below k_a, left-aligned in N-1 bits (a << (N-1-k_a), truncated to N-1 bits); f_b SHALL be formed the same way from b.
REQ-020 ADD (1 cycle): {carry, frac} = f_a + f_b, with carry as the (N)th bit, unsigned, and no saturation.
REQ-021 NORM (1 cycle): exponent e = k_a + k_b + carry, computed at L+1 bits; mantissa m = {1'b1, frac}, N bits; product = (m << e) >> (N-1), computed at 3N-1 bits and then truncated to 2N bits.
REQ-022 NORM: if zero_flag is set, product SHALL be 0.
REQ-023 The product SHALL be registered on leaving NORM; out_valid SHALL be set on the same edge and the state SHALL go to DONE.
REQ-024 Latency: out_valid SHALL first be high N+2 rising edges after the accepting edge (10 for N=8).
REQ-025 DONE: product and out_valid SHALL hold stable while out_ready=0.
REQ-026 DONE: when out_ready=1 at a rising edge, out_valid SHALL clear and the state SHALL return to IDLE; in_ready SHALL be high the following cycle, with no same-cycle re-accept.
REQ-027 out_ready SHALL be ignored in all states other than DONE.
REQ-028 product SHALL retain its last value after handshake until the next NORM completion.

Reset
REQ-029 On rst_n=0 the block SHALL, asynchronously and in any state including mid-LOD or DONE: set state=IDLE, out_valid=0, busy=0, product=0, and clear the counter, k_a, k_b, zero_flag, carry and frac.
REQ-030 in_ready SHALL be 1 while in reset and after reset release, and the first accept SHALL be possible on the first rising edge after rst_n rises.
REQ-031 A transaction interrupted by reset SHALL be discarded, and no out_valid SHALL follow.

Verification
REQ-032 N=8, a=12, b=10 -> k=3,3; f=0x40,0x20; carry=0; product=112, out_valid 10 edges after accept.
REQ-033 a=12, b=12 -> carry=1, frac=0, e=7, product=128.
REQ-034 a=255, b=255 -> carry=1, frac=0x7E, e=15, product=65024; a=1, b=1 -> product=1.
REQ-035 a=0, b=200 -> product=0 at the same fixed latency; in_valid pulsed during LOD leaves the latched operands unchanged.
REQ-036 out_ready held 0 for 5 cycles in DONE -> product/out_valid stable; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-037 rst_n asserted during the 4th LOD cycle -> immediate IDLE, all outputs 0, no out_valid; a new a=12, b=10 after release -> product=112.
